decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I (+ optional M) instruction decoder with a one-cycle registered output
// and a one-entry skid buffer so the stage sustains one instruction per cycle.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int EN_M  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic [4:0]       alu_op,
  output logic [2:0]       fmt,
  output logic [2:0]       funct3,
  output logic             reg_we,
  output logic             alu_src_imm,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic             mem_uns,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_LOAD = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;
  localparam logic [2:0] FMT_JALR = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu_op;
    logic [2:0]      fmt;
    logic [2:0]      funct3;
    logic            reg_we;
    logic            alu_src_imm;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_uns;
    logic            illegal;
  } dec_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(v);
    return XLEN'(s);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Shared funct3 -> ALU mapping for OP (funct7=0) and OP-IMM.
  function automatic logic [4:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] w, input logic [XLEN-1:0] pcv);
    dec_t        d;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  sh7;
    logic        bad;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    f3  = w[14:12];
    f7  = w[31:25];
    sh7 = f7;
    // RV64 shift immediates use bit 25 as shamt[5].
    if (XLEN == 64) sh7[0] = 1'b0;
    i_imm = {{20{w[31]}}, w[31:20]};
    s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
    b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    u_imm = {w[31:12], 12'h000};
    j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    bad = 1'b0;
    d = '0;
    d.pc     = pcv;
    d.rd     = w[11:7];
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.funct3 = f3;
    case (w[6:0])
      OPC_OP: begin
        d.fmt    = FMT_R;
        d.reg_we = 1'b1;
        if (f7 == 7'h00)                  d.alu_op = alu_base(f3);
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu_op = ALU_SRA;
        else if (f7 == 7'h01 && EN_M != 0)  d.alu_op = {2'b10, f3};
        else                                bad = 1'b1;
      end
      OPC_OPIMM: begin
        d.fmt         = FMT_I;
        d.imm         = sext32(i_imm);
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
        d.alu_op      = alu_base(f3);
        if (f3 == 3'd1 && sh7 != 7'h00) bad = 1'b1;
        if (f3 == 3'd5) begin
          if (sh7 == 7'h20)      d.alu_op = ALU_SRA;
          else if (sh7 != 7'h00) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        d.fmt         = FMT_LOAD;
        d.imm         = sext32(i_imm);
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
        d.mem_rd      = 1'b1;
        d.mem_size    = f3[1:0];
        d.mem_uns     = f3[2];
        bad           = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        d.fmt         = FMT_S;
        d.imm         = sext32(s_imm);
        d.alu_src_imm = 1'b1;
        d.mem_wr      = 1'b1;
        d.mem_size    = f3[1:0];
        bad           = (f3 > 3'd2);
      end
      OPC_BRANCH: begin
        d.fmt    = FMT_B;
        d.imm    = sext32(b_imm);
        d.alu_op = ALU_SUB;
        bad      = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LUI: begin
        d.fmt         = FMT_U;
        d.imm         = sext32(u_imm);
        d.alu_op      = ALU_PASSB;
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
      end
      OPC_AUIPC: begin
        d.fmt         = FMT_U;
        d.imm         = sext32(u_imm);
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
      end
      OPC_JAL: begin
        d.fmt         = FMT_J;
        d.imm         = sext32(j_imm);
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
      end
      OPC_JALR: begin
        d.fmt         = FMT_JALR;
        d.imm         = sext32(i_imm);
        d.alu_src_imm = 1'b1;
        d.reg_we      = 1'b1;
        bad           = (f3 != 3'd0);
      end
      default: bad = 1'b1;
    endcase
    d.illegal = bad;
    if (bad) begin
      d.reg_we = 1'b0;
      d.mem_rd = 1'b0;
      d.mem_wr = 1'b0;
    end
    if (d.rd == 5'd0) d.reg_we = 1'b0;
    return d;
  endfunction

  dec_t             dec_p0;
  dec_t             main_p1;
  dec_t             skid_p1;
  logic             vld_p1;
  logic             skid_vld_p1;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_p0;
  logic             drain_p1;

  always_comb begin
    dec_p0   = decode(instr, pc);
    acc_p0   = in_valid && in_ready_q;
    drain_p1 = vld_p1 && out_ready;
  end

  // Stage boundary p0 -> p1: main register with skid overflow; skid always drains first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_p1     <= '0;
      skid_p1     <= '0;
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (!vld_p1 || out_ready) begin
        if (skid_vld_p1) begin
          main_p1     <= skid_p1;
          vld_p1      <= 1'b1;
          skid_vld_p1 <= 1'b0;
          in_ready_q  <= 1'b1;
        end else begin
          vld_p1 <= acc_p0;
          if (acc_p0) main_p1 <= dec_p0;
        end
      end else if (acc_p0) begin
        skid_p1     <= dec_p0;
        skid_vld_p1 <= 1'b1;
        in_ready_q  <= 1'b0;
      end
      if (drain_p1 && main_p1.illegal) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = vld_p1;
  assign out_pc      = main_p1.pc;
  assign rd          = main_p1.rd;
  assign rs1         = main_p1.rs1;
  assign rs2         = main_p1.rs2;
  assign imm         = main_p1.imm;
  assign alu_op      = main_p1.alu_op;
  assign fmt         = main_p1.fmt;
  assign funct3      = main_p1.funct3;
  assign reg_we      = main_p1.reg_we;
  assign alu_src_imm = main_p1.alu_src_imm;
  assign mem_rd      = main_p1.mem_rd;
  assign mem_wr      = main_p1.mem_wr;
  assign mem_size    = main_p1.mem_size;
  assign mem_uns     = main_p1.mem_uns;
  assign illegal     = main_p1.illegal;
  assign illegal_cnt = cnt_q;

endmodule
